pipe_stage_chain: RTL and testbench

- Parametrised pipeline-register chain that replaces fixed-depth shift buffers between CPU stages.
- Carries a payload plus destination-register tag through STAGES registers, with a valid bit per stage.
- Supports per-stage stall with bubble collapsing, per-stage flush, and output backpressure.
- Provides LOOKUPS combinational forwarding ports that return the youngest in-flight result for a register address; used for EX/MEM/WB bypass and hazard detection.

---
 rtl/pipe_stage_chain.sv | 129 ++++++++++++
 tb/tb_pipe_stage_chain.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// Parametrised pipeline-register chain with per-stage stall/flush, bubble collapsing,
// output backpressure and youngest-wins combinational forwarding lookups.
module pipe_stage_chain #(
  parameter int STAGES  = 3,
  parameter int WIDTH   = 32,
  parameter int RA_W    = 5,
  parameter int LOOKUPS = 2,
  localparam int OCC_W  = $clog2(STAGES + 1),
  localparam int SIDX_W = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic [RA_W-1:0]             in_rd,
  input  logic                        in_we,
  input  logic [STAGES-1:0]           stall,
  input  logic [STAGES-1:0]           flush,
  input  logic                        out_ready,
  output logic                        out_valid,
  output logic [WIDTH-1:0]            out_data,
  output logic [RA_W-1:0]             out_rd,
  output logic                        out_we,
  output logic [STAGES-1:0]           stage_valid,
  output logic [OCC_W-1:0]            occupancy,
  input  logic [LOOKUPS*RA_W-1:0]     lookup_addr,
  output logic [LOOKUPS-1:0]          lookup_hit,
  output logic [LOOKUPS*WIDTH-1:0]    lookup_data,
  output logic [LOOKUPS*SIDX_W-1:0]   lookup_stage
);

  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0][WIDTH-1:0]  data_q, data_d;
  logic [STAGES-1:0][RA_W-1:0]   rd_q, rd_d;
  logic [STAGES-1:0]             we_q, we_d;
  logic [OCC_W-1:0]              occ_q, occ_d;
  logic [STAGES-1:0]             hold;

  // Hold propagates from the output end backwards; an empty stage breaks the chain.
  always_comb begin
    logic blk;
    hold = '0;
    blk  = ~out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      hold[k] = stall[k] | (valid_q[k] & blk);
      blk     = hold[k];
    end
  end

  assign in_ready = ~hold[0];

  always_comb begin
    logic             src_v;
    logic [WIDTH-1:0] src_data;
    logic [RA_W-1:0]  src_rd;
    logic             src_we;
    valid_d  = valid_q;
    data_d   = data_q;
    rd_d     = rd_q;
    we_d     = we_q;
    occ_d    = '0;
    src_v    = in_valid & ~hold[0];
    src_data = in_data;
    src_rd   = in_rd;
    src_we   = in_we;
    for (int k = 0; k < STAGES; k++) begin
      // A loading stage whose source holds takes a bubble and keeps its stale payload.
      if (!hold[k]) begin
        valid_d[k] = src_v;
        if (src_v) begin
          data_d[k] = src_data;
          rd_d[k]   = src_rd;
          we_d[k]   = src_we;
        end
      end
      if (flush[k]) begin
        valid_d[k] = 1'b0;
      end
      occ_d    = occ_d + OCC_W'(valid_d[k]);
      src_v    = valid_q[k] & ~hold[k];
      src_data = data_q[k];
      src_rd   = rd_q[k];
      src_we   = we_q[k];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      we_q    <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      occ_q   <= occ_d;
    end
  end

  assign out_valid   = valid_q[STAGES-1];
  assign out_data    = data_q[STAGES-1];
  assign out_rd      = rd_q[STAGES-1];
  assign out_we      = we_q[STAGES-1];
  assign stage_valid = valid_q;
  assign occupancy   = occ_q;

  // Scanning oldest to youngest lets the youngest match overwrite older ones.
  always_comb begin
    logic [RA_W-1:0] addr;
    lookup_hit   = '0;
    lookup_data  = '0;
    lookup_stage = '0;
    for (int j = 0; j < LOOKUPS; j++) begin
      addr = lookup_addr[j*RA_W +: RA_W];
      for (int k = STAGES - 1; k >= 0; k--) begin
        if ((addr != '0) && valid_q[k] && we_q[k] && (rd_q[k] == addr)) begin
          lookup_hit[j]                      = 1'b1;
          lookup_data[j*WIDTH +: WIDTH]      = data_q[k];
          lookup_stage[j*SIDX_W +: SIDX_W]   = SIDX_W'(k);
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (STAGES=3): expected outputs are queued at issue
// and a negedge monitor pops them on each output handshake.
module tb_pipe_stage_chain;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_rd;
  logic        in_we;
  logic [2:0]  stall;
  logic [2:0]  flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_we;
  logic [2:0]  stage_valid;
  logic [1:0]  occupancy;
  logic [9:0]  lookup_addr;
  logic [1:0]  lookup_hit;
  logic [63:0] lookup_data;
  logic [3:0]  lookup_stage;

  int n_cmp = 0;
  int n_err = 0;
  logic [37:0] exp_q[$];

  pipe_stage_chain #(.STAGES(3), .WIDTH(32), .RA_W(5), .LOOKUPS(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rd(in_rd), .in_we(in_we),
    .stall(stall), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd), .out_we(out_we),
    .stage_valid(stage_valid), .occupancy(occupancy),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
    .lookup_data(lookup_data), .lookup_stage(lookup_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [4:0] rd, input logic we, input bit expect_out);
    in_valid = 1'b1;
    in_data  = d;
    in_rd    = rd;
    in_we    = we;
    if (expect_out) exp_q.push_back({we, rd, d});
    step();
    in_valid = 1'b0;
  endtask

  // Monitor: every consumed output entry must match the head of the queue.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready && !stall[2]) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out: got %0h expected none", {out_we, out_rd, out_data});
      end else begin
        chk("out_entry", {26'd0, out_we, out_rd, out_data}, {26'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard;
    reset = 1'b0; in_valid = 1'b0; in_data = '0; in_rd = '0; in_we = 1'b0;
    stall = '0; flush = '0; out_ready = 1'b0; lookup_addr = '0;

    // Reset state
    #12;
    chk("rst_stage_valid", stage_valid, 3'b000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_occupancy", occupancy, 2'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_lookup_hit", lookup_hit, 2'b00);
    step();
    reset = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);

    // Streaming with out_ready high
    out_ready = 1'b1;
    send(32'h11, 5'd1, 1'b1, 1'b1);
    send(32'h22, 5'd2, 1'b1, 1'b1);
    chk("lat_not_yet", out_valid, 1'b0);
    send(32'h33, 5'd3, 1'b1, 1'b1);
    chk("lat_first_valid", out_valid, 1'b1);
    chk("lat_first_data", out_data, 32'h11);
    chk("stream_occ_peak", occupancy, 2'd3);
    send(32'h44, 5'd4, 1'b0, 1'b1);
    chk("stream_occ_full", occupancy, 2'd3);
    repeat (3) step();
    chk("stream_drained", stage_valid, 3'b000);
    chk("stream_occ_zero", occupancy, 2'd0);

    // Full pipe with backpressure
    out_ready = 1'b0;
    send(32'hA1, 5'd6, 1'b1, 1'b1);
    send(32'hA2, 5'd7, 1'b1, 1'b1);
    send(32'hA3, 5'd8, 1'b1, 1'b1);
    chk("bp_full", stage_valid, 3'b111);
    chk("bp_in_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_data = 32'hDD; in_rd = 5'd9; in_we = 1'b1;
    repeat (5) step();
    chk("bp_stable_valid", stage_valid, 3'b111);
    chk("bp_stable_data", out_data, 32'hA1);
    chk("bp_stable_occ", occupancy, 2'd3);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    chk("bp_drained", stage_valid, 3'b000);

    // Bubble collapsing behind a blocked output
    out_ready = 1'b0;
    send(32'h5A, 5'd10, 1'b1, 1'b1);
    step();
    step();
    chk("bc_only_s2", stage_valid, 3'b100);
    chk("bc_in_ready", in_ready, 1'b1);
    send(32'h5B, 5'd11, 1'b1, 1'b1);
    chk("bc_fill1", stage_valid, 3'b101);
    send(32'h5C, 5'd12, 1'b1, 1'b1);
    chk("bc_fill2", stage_valid, 3'b111);
    chk("bc_in_ready_low", in_ready, 1'b0);
    out_ready = 1'b1;
    repeat (3) step();
    chk("bc_drained", stage_valid, 3'b000);

    // Middle-stage stall: oldest drains, bubble forms behind it
    out_ready = 1'b0;
    send(32'hB1, 5'd13, 1'b1, 1'b1);
    send(32'hB2, 5'd14, 1'b1, 1'b1);
    send(32'hB3, 5'd15, 1'b1, 1'b1);
    stall = 3'b010;
    out_ready = 1'b1;
    #1;
    chk("st_in_ready", in_ready, 1'b0);
    step();
    chk("st_bubble", stage_valid, 3'b011);
    chk("st_out_valid", out_valid, 1'b0);
    chk("st_in_ready2", in_ready, 1'b0);
    stall = 3'b000;
    step();
    chk("st_release", stage_valid, 3'b110);
    chk("st_release_data", out_data, 32'hB2);
    repeat (2) step();
    chk("st_drained", stage_valid, 3'b000);

    // Flush of stages 0 and 1 while stage 0 is stalled and output blocked
    out_ready = 1'b0;
    send(32'hC1, 5'd16, 1'b1, 1'b1);
    send(32'hC2, 5'd17, 1'b1, 1'b0);
    send(32'hC3, 5'd18, 1'b1, 1'b0);
    stall = 3'b001;
    flush = 3'b011;
    #1;
    chk("fl_in_ready", in_ready, 1'b0);
    step();
    chk("fl_valid", stage_valid, 3'b100);
    chk("fl_occ", occupancy, 2'd1);
    chk("fl_out_data", out_data, 32'hC1);
    stall = 3'b000;
    flush = 3'b000;
    out_ready = 1'b1;
    step();
    chk("fl_drained", stage_valid, 3'b000);

    // flush[0] discards an entry accepted in the same cycle
    flush = 3'b001;
    in_valid = 1'b1; in_data = 32'hF0; in_rd = 5'd19; in_we = 1'b1;
    #1;
    chk("fl0_in_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    flush = 3'b000;
    chk("fl0_valid", stage_valid, 3'b000);
    chk("fl0_occ", occupancy, 2'd0);

    // Forwarding lookups
    out_ready = 1'b0;
    send(32'hBBBB, 5'd5, 1'b1, 1'b0);
    send(32'hCCCC, 5'd0, 1'b1, 1'b0);
    send(32'hAAAA, 5'd5, 1'b1, 1'b0);
    lookup_addr = {5'd0, 5'd5};
    #1;
    chk("lk_hit", lookup_hit, 2'b01);
    chk("lk_data", lookup_data, {32'h0, 32'hAAAA});
    chk("lk_stage", lookup_stage, 4'b0000);
    lookup_addr = {5'd5, 5'd5};
    #1;
    chk("lk_same_hit", lookup_hit, 2'b11);
    chk("lk_same_data", lookup_data, {32'hAAAA, 32'hAAAA});
    flush = 3'b001;
    step();
    flush = 3'b000;
    chk("lk_old_hit", lookup_hit, 2'b11);
    chk("lk_old_data", lookup_data, {32'hBBBB, 32'hBBBB});
    chk("lk_old_stage", lookup_stage, 4'b1010);
    lookup_addr = {5'd7, 5'd5};
    #1;
    chk("lk_miss_hit", lookup_hit, 2'b01);
    chk("lk_miss_data", lookup_data[63:32], 32'h0);
    flush = 3'b111;
    step();
    flush = 3'b000;
    chk("lk_flushed_valid", stage_valid, 3'b000);
    chk("lk_flushed_hit", lookup_hit, 2'b00);
    lookup_addr = '0;

    // Asynchronous reset mid-cycle with a full pipe
    out_ready = 1'b0;
    send(32'hD1, 5'd20, 1'b1, 1'b0);
    send(32'hD2, 5'd21, 1'b1, 1'b0);
    send(32'hD3, 5'd22, 1'b1, 1'b0);
    chk("ar_full", stage_valid, 3'b111);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_stage_valid", stage_valid, 3'b000);
    chk("ar_out_valid", out_valid, 1'b0);
    chk("ar_occ", occupancy, 2'd0);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_in_ready", in_ready, 1'b1);
    step();
    out_ready = 1'b1;
    send(32'h77, 5'd3, 1'b1, 1'b1);

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      step();
      guard++;
    end
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_stage_valid", stage_valid, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
